// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store port: access sizes, FSM states,
// byte-enable generation and store-data lane replication.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] o);
        case (size)
            SZ_BYTE: byte_en = 4'b0001 << o;
            SZ_HALF: byte_en = 4'b0011 << o;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    // Replicate the right-justified store data across all lanes so whichever
    // lanes are enabled see the correct bytes.
    function automatic logic [31:0] store_rep(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: store_rep = {4{wdata[7:0]}};
            SZ_HALF: store_rep = {2{wdata[15:0]}};
            default: store_rep = wdata;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Load aligner: shifts the addressed lane down to bit 0 and sign/zero extends
// to 32 bits. Purely combinational.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {off, 3'b000};
        case (size)
            SZ_BYTE: data = is_unsigned ? {24'h0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: data = is_unsigned ? {16'h0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_port.sv
// Single-request load/store initiator for one port of the byte-enabled memory.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word accesses fault
// instead of having their offending low address bits forced to zero.
module lsu_port
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [3:0]        mem_data_en,
    output logic              mem_write_en
);

    state_e state, state_nxt;

    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              we_q;
    logic [1:0]        off_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [31:0]       rdata_q;
    logic              fault_q;

    logic [1:0]  raw_o, eff_o;
    logic        range_flt, size_flt, mis_flt, dec_fault;
    logic [31:0] aligned;

    // Request decode
    always_comb begin
        raw_o     = req_addr[1:0];
        range_flt = |req_addr[31:ADDR_W];
        size_flt  = (req_size == 2'd3);
`ifdef MISALIGN_TRAP_EN
        mis_flt = ((req_size == SZ_HALF) && raw_o[0]) ||
                  ((req_size == SZ_WORD) && (raw_o != 2'b00));
        eff_o   = raw_o;
`else
        mis_flt = 1'b0;
        case (req_size)
            SZ_HALF: eff_o = raw_o & 2'b10;
            SZ_WORD: eff_o = 2'b00;
            default: eff_o = raw_o;
        endcase
`endif
        dec_fault = range_flt | size_flt | mis_flt;
    end

    lsu_align u_align (
        .rdata       (mem_rdata),
        .off         (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .data        (aligned)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = dec_fault ? RESP : ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            off_q   <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    rdata_q <= '0;
                    if (dec_fault) begin
                        fault_q <= 1'b1;
                    end else begin
                        fault_q <= 1'b0;
                        addr_q  <= req_addr[ADDR_W-1:0];
                        wdata_q <= store_rep(req_size, req_wdata);
                        be_q    <= byte_en(req_size, eff_o);
                        we_q    <= req_we;
                        off_q   <= eff_o;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                    end
                end
                // Memory read data is valid in the cycle after ISSUE.
                WAIT: rdata_q <= we_q ? 32'h0 : aligned;
                default: ;
            endcase
        end
    end

    // Strobes are gated by reset so a reset landing in ISSUE suppresses the write.
    assign mem_write_en = (state == ISSUE) && !rst && we_q;
    assign mem_data_en  = ((state == ISSUE) && !rst) ? be_q : 4'b0000;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign req_ready    = (state == IDLE) && !rst;
    assign rsp_valid    = (state == RESP);
    assign rsp_rdata    = rdata_q;
    assign rsp_fault    = fault_q;

endmodule
